// File: rtl/hazard_unit_mdu_if.sv
// hazard_unit_mdu_if: pipeline-control inputs and stall/forward/counter outputs of the hazard unit
interface hazard_unit_mdu_if #(parameter int RA_W = 5, parameter int CNT_W = 16);
  logic BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MduStartE, MduUseD;
  logic [RA_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MduBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] CntLoad, CntBranch, CntMdu;
  modport master (
    output BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MduStartE, MduUseD,
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, MduBusy, ForwardAE, ForwardBE,
    input  CntLoad, CntBranch, CntMdu
  );
  modport slave (
    input  BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MduStartE, MduUseD,
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, MduBusy, ForwardAE, ForwardBE,
    output CntLoad, CntBranch, CntMdu
  );
endinterface

// File: rtl/hazard_unit_mdu.sv
// hazard_unit_mdu: forwarding, load-use/branch/MDU stall detection with saturating per-cause stall counters
module hazard_unit_mdu #(
  parameter int RA_W        = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic reset,
  hazard_unit_mdu_if.slave hz
);
  localparam int RW = $clog2(MDU_LATENCY) + 1;
  localparam bit MULTI = MDU_LATENCY >= 2;
  logic [RW-1:0] remain;
  logic [CNT_W-1:0] cntLoad, cntBranch, cntMdu;
  logic lwStall, brStall, mduStall, stall;
  function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return a != '0 && a == b;
  endfunction
  assign hz.ForwardAE = hz.RegWriteM && hit(hz.RsE, hz.WriteRegM) ? 2'b10 :
                        hz.RegWriteW && hit(hz.RsE, hz.WriteRegW) ? 2'b01 : 2'b00;
  assign hz.ForwardBE = hz.RegWriteM && hit(hz.RtE, hz.WriteRegM) ? 2'b10 :
                        hz.RegWriteW && hit(hz.RtE, hz.WriteRegW) ? 2'b01 : 2'b00;
  assign hz.ForwardAD = hz.RegWriteM && hit(hz.RsD, hz.WriteRegM);
  assign hz.ForwardBD = hz.RegWriteM && hit(hz.RtD, hz.WriteRegM);
  assign lwStall = hz.MemToRegE && hz.RegWriteE &&
                   (hit(hz.RsD, hz.WriteRegE) || hit(hz.RtD, hz.WriteRegE));
  assign brStall = hz.BranchD &&
                   ((hz.RegWriteE && (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD))) ||
                    (hz.MemToRegM && (hit(hz.WriteRegM, hz.RsD) || hit(hz.WriteRegM, hz.RtD))));
  // the start cycle itself stalls a dependent, before the counter has been loaded
  assign hz.MduBusy = remain != '0;
  assign mduStall = hz.MduUseD && (hz.MduBusy || (hz.MduStartE && MULTI));
  assign stall = lwStall || brStall || mduStall;
  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;
  assign hz.CntLoad = cntLoad;
  assign hz.CntBranch = cntBranch;
  assign hz.CntMdu = cntMdu;
  always_ff @(posedge clk) begin
    if (reset) begin
      remain <= '0;
      cntLoad <= '0;
      cntBranch <= '0;
      cntMdu <= '0;
    end else begin
      remain <= hz.MduStartE && MULTI ? RW'(MDU_LATENCY - 2) :
                remain != '0 ? remain - RW'(1) : remain;
      if (lwStall && !(&cntLoad)) cntLoad <= cntLoad + CNT_W'(1);
      if (brStall && !lwStall && !(&cntBranch)) cntBranch <= cntBranch + CNT_W'(1);
      if (mduStall && !lwStall && !brStall && !(&cntMdu)) cntMdu <= cntMdu + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_unit_mdu.sv
// tb_hazard_unit_mdu: directed and random checks of two builds (MDU_LATENCY 4 and 1) against a cycle-indexed model
module tb_hazard_unit_mdu;
  localparam int CW = 4;
  localparam int CMAX = 2 ** CW - 1;
  localparam int LAT [2] = '{4, 1};
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nVec = 0, nErr = 0, cyc = 0;
  int ls [2] = '{-100, -100};
  int cl [2] = '{0, 0};
  int cb [2] = '{0, 0};
  int cm [2] = '{0, 0};
  hazard_unit_mdu_if #(.RA_W(5), .CNT_W(CW)) h4 ();
  hazard_unit_mdu_if #(.RA_W(5), .CNT_W(CW)) h1 ();
  hazard_unit_mdu #(.RA_W(5), .MDU_LATENCY(4), .CNT_W(CW)) dut4 (.clk(clk), .reset(reset), .hz(h4));
  hazard_unit_mdu #(.RA_W(5), .MDU_LATENCY(1), .CNT_W(CW)) dut1 (.clk(clk), .reset(reset), .hz(h1));
  always #5 clk = ~clk;
  always_comb begin
    h1.BranchD = h4.BranchD;
    h1.MemToRegE = h4.MemToRegE;
    h1.RegWriteE = h4.RegWriteE;
    h1.MemToRegM = h4.MemToRegM;
    h1.RegWriteM = h4.RegWriteM;
    h1.RegWriteW = h4.RegWriteW;
    h1.MduStartE = h4.MduStartE;
    h1.MduUseD = h4.MduUseD;
    h1.RsD = h4.RsD;
    h1.RtD = h4.RtD;
    h1.RsE = h4.RsE;
    h1.RtE = h4.RtE;
    h1.WriteRegE = h4.WriteRegE;
    h1.WriteRegM = h4.WriteRegM;
    h1.WriteRegW = h4.WriteRegW;
  end
  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return a != 5'd0 && a == b;
  endfunction
  function automatic int sat(input int x);
    return x >= CMAX ? CMAX : x + 1;
  endfunction
  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (h4.RegWriteM && hit(src, h4.WriteRegM)) return 2'b10;
    if (h4.RegWriteW && hit(src, h4.WriteRegW)) return 2'b01;
    return 2'b00;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic clearIn();
    {h4.BranchD, h4.MemToRegE, h4.RegWriteE, h4.MemToRegM, h4.RegWriteM, h4.RegWriteW} = '0;
    {h4.MduStartE, h4.MduUseD} = '0;
    {h4.RsD, h4.RtD, h4.RsE, h4.RtE, h4.WriteRegE, h4.WriteRegM, h4.WriteRegW} = '0;
  endtask
  // one clock: compare all outputs to the model, then advance the model across the edge
  task automatic step(input bit chk);
    bit lw, br;
    bit md [2];
    bit busy [2];
    #1;
    lw = h4.MemToRegE && h4.RegWriteE && (hit(h4.RsD, h4.WriteRegE) || hit(h4.RtD, h4.WriteRegE));
    br = h4.BranchD && ((h4.RegWriteE && (hit(h4.WriteRegE, h4.RsD) || hit(h4.WriteRegE, h4.RtD))) ||
                        (h4.MemToRegM && (hit(h4.WriteRegM, h4.RsD) || hit(h4.WriteRegM, h4.RtD))));
    for (int k = 0; k < 2; k++) begin
      busy[k] = cyc >= ls[k] + 1 && cyc <= ls[k] + LAT[k] - 2;
      md[k] = h4.MduUseD && LAT[k] >= 2 && (busy[k] || h4.MduStartE);
    end
    if (chk) begin
      check("ForwardAE", 32'(h4.ForwardAE), 32'(fwdSel(h4.RsE)));
      check("ForwardBE", 32'(h4.ForwardBE), 32'(fwdSel(h4.RtE)));
      check("ForwardAD", 32'(h4.ForwardAD), 32'(h4.RegWriteM && hit(h4.RsD, h4.WriteRegM)));
      check("ForwardBD", 32'(h4.ForwardBD), 32'(h4.RegWriteM && hit(h4.RtD, h4.WriteRegM)));
      check("stall_L4", 32'({h4.StallF, h4.StallD, h4.FlushE}), 32'({3{lw | br | md[0]}}));
      check("stall_L1", 32'({h1.StallF, h1.StallD, h1.FlushE}), 32'({3{lw | br | md[1]}}));
      check("MduBusy_L4", 32'(h4.MduBusy), 32'(busy[0]));
      check("MduBusy_L1", 32'(h1.MduBusy), 32'(busy[1]));
      check("CntLoad_L4", 32'(h4.CntLoad), cl[0]);
      check("CntBranch_L4", 32'(h4.CntBranch), cb[0]);
      check("CntMdu_L4", 32'(h4.CntMdu), cm[0]);
      check("CntMdu_L1", 32'(h1.CntMdu), cm[1]);
      check("CntLoad_L1", 32'(h1.CntLoad), cl[1]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ls[k] = -100;
        cl[k] = 0;
        cb[k] = 0;
        cm[k] = 0;
      end else begin
        if (lw) cl[k] = sat(cl[k]);
        else if (br) cb[k] = sat(cb[k]);
        else if (md[k]) cm[k] = sat(cm[k]);
        if (h4.MduStartE) ls[k] = cyc;
      end
    end
    cyc++;
    #1;
  endtask
  initial begin
    bit s4 [4] = '{1, 1, 1, 0};
    bit b4 [4] = '{0, 1, 1, 0};
    int cmBefore;
    clearIn();
    step(0);
    step(1);
    reset = 1'b0;
    step(1);
    // forwarding priority
    h4.WriteRegM = 5'd5; h4.WriteRegW = 5'd5; h4.RegWriteM = 1'b1; h4.RegWriteW = 1'b1; h4.RsE = 5'd5;
    #1 check("t1_fwd_M", 32'(h4.ForwardAE), 32'd2);
    h4.RegWriteM = 1'b0;
    #1 check("t1_fwd_W", 32'(h4.ForwardAE), 32'd1);
    h4.RsE = 5'd0;
    #1 check("t1_fwd_r0", 32'(h4.ForwardAE), 32'd0);
    step(1);
    // load-use
    clearIn();
    h4.MemToRegE = 1'b1; h4.RegWriteE = 1'b1; h4.WriteRegE = 5'd8; h4.RtD = 5'd8;
    #1 check("t2_lw_stall", 32'({h4.StallF, h4.StallD, h4.FlushE}), 32'd7);
    step(1);
    clearIn();
    #1 check("t2_CntLoad", 32'(h4.CntLoad), 32'd1);
    check("t2_no_stall", 32'(h4.StallF), 32'd0);
    step(1);
    // branch waiting on a load in M, then forwarding from M
    h4.BranchD = 1'b1; h4.RsD = 5'd9; h4.MemToRegM = 1'b1; h4.WriteRegM = 5'd9;
    #1 check("t3_br_stall", 32'(h4.StallD), 32'd1);
    check("t3_fad_off", 32'(h4.ForwardAD), 32'd0);
    step(1);
    h4.MemToRegM = 1'b0; h4.RegWriteM = 1'b1;
    #1 check("t3_fad_on", 32'(h4.ForwardAD), 32'd1);
    check("t3_no_stall", 32'(h4.StallD), 32'd0);
    step(1);
    // MDU op with a dependent held in D
    clearIn();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    h4.MduStartE = 1'b1; h4.MduUseD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("t4_stall", 32'(h4.StallF), 32'(s4[i]));
      check("t4_busy", 32'(h4.MduBusy), 32'(b4[i]));
      check("t4_L1_stall", 32'(h1.StallF), 32'd0);
      step(1);
      h4.MduStartE = 1'b0;
    end
    #1 check("t4_CntMdu", 32'(h4.CntMdu), 32'd3);
    step(1);
    // overlapping causes count once, under the load cause
    h4.MduStartE = 1'b1;
    h4.MemToRegE = 1'b1; h4.RegWriteE = 1'b1; h4.WriteRegE = 5'd3; h4.RsD = 5'd3;
    cmBefore = cm[0];
    #1 check("t5_single_stall", 32'({h4.StallF, h4.StallD, h4.FlushE}), 32'd7);
    step(1);
    h4.MduStartE = 1'b0;
    #1 check("t5_CntMdu_held", 32'(h4.CntMdu), cmBefore);
    for (int i = 0; i < 20; i++) step(1);
    #1 check("t5_CntLoad_sat", 32'(h4.CntLoad), CMAX);
    step(1);
    // reset in the middle of an MDU op
    clearIn();
    h4.MduStartE = 1'b1;
    step(1);
    h4.MduStartE = 1'b0;
    #1 check("t6_busy_before", 32'(h4.MduBusy), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    #1 check("t6_busy_after", 32'(h4.MduBusy), 32'd0);
    check("t6_cnt_after", 32'({h4.CntLoad, h4.CntBranch, h4.CntMdu}), 32'd0);
    step(1);
    // random traffic with small register numbers to provoke hits and overlaps
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 39) == 0;
      h4.BranchD = $urandom_range(0, 2) == 0;
      h4.MemToRegE = $urandom_range(0, 1) == 0;
      h4.RegWriteE = $urandom_range(0, 3) != 0;
      h4.MemToRegM = $urandom_range(0, 3) == 0;
      h4.RegWriteM = $urandom_range(0, 1) == 0;
      h4.RegWriteW = $urandom_range(0, 1) == 0;
      h4.MduStartE = $urandom_range(0, 5) == 0;
      h4.MduUseD = $urandom_range(0, 1) == 0;
      h4.RsD = 5'($urandom_range(0, 3));
      h4.RtD = 5'($urandom_range(0, 3));
      h4.RsE = 5'($urandom_range(0, 3));
      h4.RtE = 5'($urandom_range(0, 3));
      h4.WriteRegE = 5'($urandom_range(0, 3));
      h4.WriteRegM = 5'($urandom_range(0, 3));
      h4.WriteRegW = 5'($urandom_range(0, 3));
      step(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
